// File: rtl/rd_burst_scheduler.sv
// rd_burst_scheduler: splits read jobs into 4 KB-safe AXI bursts, round-robins active slots,
// and tags returning beats with the id of the job that issued their burst.
module rd_burst_scheduler #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 512,
    parameter int LEN_WIDTH  = 35,
    parameter int ID_WIDTH   = 16,
    parameter int MAX_BURST  = 64,
    parameter int NUM_SLOTS  = 2,
    parameter int TAG_DEPTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  job_valid,
    output logic                  job_ready,
    input  logic [ADDR_WIDTH-1:0] job_src_addr,
    input  logic [LEN_WIDTH-1:0]  job_length,
    input  logic [ID_WIDTH-1:0]   job_id,
    output logic                  rd_req,
    input  logic                  rd_req_ack,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [7:0]            rd_len,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid_in,
    input  logic                  data_last_in,
    output logic                  data_ready_out,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [ID_WIDTH-1:0]   data_id_out,
    output logic                  data_last_out,
    output logic                  data_valid_out,
    input  logic                  data_ready_in,
    output logic                  idle,
    output logic                  err
);
    localparam int BEAT_BYTES = DATA_WIDTH / 8;
    localparam int OFF = $clog2(BEAT_BYTES);
    localparam int SW = NUM_SLOTS > 1 ? $clog2(NUM_SLOTS) : 1;
    localparam int TW = $clog2(TAG_DEPTH);
    localparam int NW = 14;

    typedef enum logic [1:0] {IDLE, PICK, REQ} state_t;

    state_t                state, state_nx;
    logic [NUM_SLOTS-1:0]  slot_valid;
    logic [ADDR_WIDTH-1:0] slot_addr [NUM_SLOTS];
    logic [LEN_WIDTH-1:0]  slot_rem  [NUM_SLOTS];
    logic [ID_WIDTH-1:0]   slot_id   [NUM_SLOTS];
    logic [SW-1:0]         rr, sel, pick_idx, free_idx;
    logic                  pick_found;
    logic [NW-1:0]         bnd, cap, n_pick, n_q;
    logic [LEN_WIDTH-1:0]  job_beats;
    logic [ID_WIDTH-1:0]   tag_mem [TAG_DEPTH];
    logic [TW-1:0]         tag_wp, tag_rp;
    logic [TW:0]           tag_cnt;
    logic                  tag_push, tag_pop, tag_empty, beat_acc, job_acc, ack;

    assign job_ready = ~&slot_valid;
    assign job_acc = job_valid & job_ready;
    assign job_beats = (job_length >> OFF) + LEN_WIDTH'(|job_length[OFF-1:0]);
    assign ack = (state == REQ) & rd_req_ack;

    always_comb begin
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (!slot_valid[SW'(i)]) free_idx = SW'(i);
    end

    always_comb begin
        pick_idx = rr;
        pick_found = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++)
            if (!pick_found && slot_valid[SW'((int'(rr) + i) % NUM_SLOTS)]) begin
                pick_idx = SW'((int'(rr) + i) % NUM_SLOTS);
                pick_found = 1'b1;
            end
    end

    // Beats left before the next 4 KB page, then capped by MAX_BURST and the job remainder
    assign bnd = NW'(4096 >> OFF) - NW'(slot_addr[pick_idx][11:OFF]);
    assign cap = bnd < NW'(MAX_BURST) ? bnd : NW'(MAX_BURST);
    assign n_pick = slot_rem[pick_idx] < LEN_WIDTH'(cap) ? NW'(slot_rem[pick_idx]) : cap;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nx;
    end

    always_comb begin
        state_nx = state == IDLE ? ((|slot_valid && tag_cnt < (TW+1)'(TAG_DEPTH)) ? PICK : IDLE) :
                   state == PICK ? REQ : (rd_req_ack ? IDLE : REQ);
    end

    always_comb begin
        rd_req = state == REQ;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_valid <= '0;
            rr <= '0;
            sel <= '0;
            n_q <= '0;
            rd_addr <= '0;
            rd_len <= '0;
        end else begin
            if (state == PICK) begin
                sel <= pick_idx;
                n_q <= n_pick;
                rd_addr <= slot_addr[pick_idx];
                rd_len <= 8'(n_pick - 1'b1);
            end
            if (ack) begin
                slot_addr[sel] <= slot_addr[sel] + (ADDR_WIDTH'(n_q) << OFF);
                slot_rem[sel] <= slot_rem[sel] - LEN_WIDTH'(n_q);
                if (slot_rem[sel] == LEN_WIDTH'(n_q)) slot_valid[sel] <= 1'b0;
                rr <= sel == SW'(NUM_SLOTS - 1) ? '0 : sel + 1'b1;
            end
            // The freed slot is still marked valid this cycle, so a new job never lands on sel
            if (job_acc && job_length != '0) begin
                slot_valid[free_idx] <= 1'b1;
                slot_addr[free_idx] <= job_src_addr & ~ADDR_WIDTH'(BEAT_BYTES - 1);
                slot_rem[free_idx] <= job_beats;
                slot_id[free_idx] <= job_id;
            end
        end
    end

    assign tag_empty = tag_cnt == '0;
    assign data_ready_out = data_ready_in | ~data_valid_out;
    assign beat_acc = data_valid_in & data_ready_out;
    assign tag_pop = beat_acc & data_last_in & ~tag_empty;
    assign tag_push = ack;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tag_wp <= '0;
            tag_rp <= '0;
            tag_cnt <= '0;
        end else begin
            if (tag_push) begin
                tag_mem[tag_wp] <= slot_id[sel];
                tag_wp <= tag_wp + 1'b1;
            end
            if (tag_pop) tag_rp <= tag_rp + 1'b1;
            tag_cnt <= tag_cnt + (TW+1)'(tag_push) - (TW+1)'(tag_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            data_out <= '0;
            data_id_out <= '0;
            data_last_out <= 1'b0;
            data_valid_out <= 1'b0;
            err <= 1'b0;
        end else begin
            if (beat_acc) begin
                data_out <= data_in;
                data_last_out <= data_last_in;
                data_id_out <= tag_empty ? '0 : tag_mem[tag_rp];
                data_valid_out <= 1'b1;
            end else if (data_ready_in) begin
                data_valid_out <= 1'b0;
            end
            if (beat_acc && tag_empty) err <= 1'b1;
        end
    end

    assign idle = ~|slot_valid & tag_empty & ~data_valid_out;
endmodule

// File: tb/tb_rd_burst_scheduler.sv
// tb_rd_burst_scheduler: directed scenarios for burst splitting, round-robin interleave,
// tag FIFO back-pressure and error handling, with hand-computed expectations.
`timescale 1ns/1ps
module tb_rd_burst_scheduler;
    localparam int AW = 64, DW = 512, LW = 35, IW = 16;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          job_valid = 1'b0, job_ready;
    logic [AW-1:0] job_src_addr = '0;
    logic [LW-1:0] job_length = '0;
    logic [IW-1:0] job_id = '0;
    logic          rd_req, rd_req_ack = 1'b0;
    logic [AW-1:0] rd_addr;
    logic [7:0]    rd_len;
    logic [DW-1:0] data_in = '0, data_out;
    logic          data_valid_in = 1'b0, data_last_in = 1'b0, data_ready_out;
    logic [IW-1:0] data_id_out;
    logic          data_last_out, data_valid_out, data_ready_in = 1'b1, idle, err;

    int n_cmp = 0, n_bad = 0;
    logic [AW-1:0] req_addr [$];
    logic [7:0]    req_len  [$];

    always #5 clk = ~clk;

    rd_burst_scheduler dut (
        .clk(clk), .rst_n(rst_n),
        .job_valid(job_valid), .job_ready(job_ready), .job_src_addr(job_src_addr),
        .job_length(job_length), .job_id(job_id),
        .rd_req(rd_req), .rd_req_ack(rd_req_ack), .rd_addr(rd_addr), .rd_len(rd_len),
        .data_in(data_in), .data_valid_in(data_valid_in), .data_last_in(data_last_in),
        .data_ready_out(data_ready_out), .data_out(data_out), .data_id_out(data_id_out),
        .data_last_out(data_last_out), .data_valid_out(data_valid_out),
        .data_ready_in(data_ready_in), .idle(idle), .err(err)
    );

    task automatic do_reset();
        rst_n = 1'b0;
        job_valid = 1'b0;
        rd_req_ack = 1'b0;
        data_valid_in = 1'b0;
        data_last_in = 1'b0;
        data_ready_in = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic push_job(input logic [AW-1:0] a, input logic [LW-1:0] l, input logic [IW-1:0] id, output logic acc);
        job_src_addr = a;
        job_length = l;
        job_id = id;
        job_valid = 1'b1;
        acc = job_ready;
        @(negedge clk);
        job_valid = 1'b0;
    endtask

    // Acks every request while recording it, until n seen or budget cycles elapse
    task automatic collect(input int n, input int budget, output int got);
        req_addr.delete();
        req_len.delete();
        got = 0;
        rd_req_ack = 1'b1;
        for (int c = 0; c < budget && got < n; c++) begin
            if (rd_req) begin
                req_addr.push_back(rd_addr);
                req_len.push_back(rd_len);
                got++;
            end
            @(negedge clk);
        end
        rd_req_ack = 1'b0;
    endtask

    task automatic send_burst(input int beats, input int base, output logic [IW-1:0] id, output logic last, output logic [DW-1:0] d);
        data_ready_in = 1'b1;
        for (int k = 0; k < beats; k++) begin
            data_in = DW'(base + k);
            data_valid_in = 1'b1;
            data_last_in = (k == beats - 1);
            @(negedge clk);
        end
        id = data_id_out;
        last = data_last_out;
        d = data_out;
        data_valid_in = 1'b0;
        data_last_in = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (rd_req !== 1'b0) begin n_bad++; $display("FAIL reset_rd_req: got %b want 0", rd_req); end
        n_cmp++; if (rd_addr !== '0 || rd_len !== 8'd0) begin n_bad++; $display("FAIL reset_rd_addr_len: got %0h/%0d want 0/0", rd_addr, rd_len); end
        n_cmp++; if (data_valid_out !== 1'b0 || data_out !== '0 || data_id_out !== '0 || data_last_out !== 1'b0) begin n_bad++; $display("FAIL reset_data_out: valid %b id %0h last %b", data_valid_out, data_id_out, data_last_out); end
        n_cmp++; if (err !== 1'b0 || idle !== 1'b1) begin n_bad++; $display("FAIL reset_err_idle: got err %b idle %b want 0 1", err, idle); end
        n_cmp++; if (job_ready !== 1'b1) begin n_bad++; $display("FAIL reset_job_ready: got %b want 1", job_ready); end
    endtask

    task automatic test_two_burst();
        logic acc, last;
        logic [IW-1:0] id;
        logic [DW-1:0] d;
        int got;
        do_reset();
        push_job(64'h1000, 8192, 16'd3, acc);
        n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL two_accept: got %b want 1", acc); end
        collect(2, 40, got);
        n_cmp++; if (got != 2) begin n_bad++; $display("FAIL two_count: got %0d want 2", got); end
        if (got == 2) begin
            n_cmp++; if (req_addr[0] !== 64'h1000 || req_len[0] !== 8'd63) begin n_bad++; $display("FAIL two_req0: got %0h/%0d want 1000/63", req_addr[0], req_len[0]); end
            n_cmp++; if (req_addr[1] !== 64'h2000 || req_len[1] !== 8'd63) begin n_bad++; $display("FAIL two_req1: got %0h/%0d want 2000/63", req_addr[1], req_len[1]); end
        end
        n_cmp++; if (job_ready !== 1'b1 || idle !== 1'b0) begin n_bad++; $display("FAIL two_after_ack: job_ready %b idle %b want 1 0", job_ready, idle); end
        send_burst(64, 0, id, last, d);
        n_cmp++; if (id !== 16'd3 || last !== 1'b1 || d !== DW'(63)) begin n_bad++; $display("FAIL two_beat0: id %0d last %b data %0h want 3 1 3f", id, last, d[31:0]); end
        send_burst(64, 1000, id, last, d);
        n_cmp++; if (id !== 16'd3 || d !== DW'(1063)) begin n_bad++; $display("FAIL two_beat1: id %0d data %0d want 3 1063", id, d[31:0]); end
        n_cmp++; if (idle !== 1'b1 || data_valid_out !== 1'b0) begin n_bad++; $display("FAIL two_drain: idle %b valid %b want 1 0", idle, data_valid_out); end
    endtask

    task automatic test_4k_split();
        logic acc, last;
        logic [IW-1:0] id;
        logic [DW-1:0] d;
        int got;
        push_job(64'h1F80, 512, 16'd7, acc);
        collect(2, 40, got);
        n_cmp++; if (got != 2) begin n_bad++; $display("FAIL split_count: got %0d want 2", got); end
        if (got == 2) begin
            n_cmp++; if (req_addr[0] !== 64'h1F80 || req_len[0] !== 8'd1) begin n_bad++; $display("FAIL split_req0: got %0h/%0d want 1f80/1", req_addr[0], req_len[0]); end
            n_cmp++; if (req_addr[1] !== 64'h2000 || req_len[1] !== 8'd5) begin n_bad++; $display("FAIL split_req1: got %0h/%0d want 2000/5", req_addr[1], req_len[1]); end
        end
        send_burst(2, 0, id, last, d);
        send_burst(6, 0, id, last, d);
        n_cmp++; if (id !== 16'd7 || idle !== 1'b1) begin n_bad++; $display("FAIL split_drain: id %0d idle %b want 7 1", id, idle); end
    endtask

    task automatic test_small_and_zero();
        logic acc, last, ok;
        logic [IW-1:0] id;
        logic [DW-1:0] d;
        int got;
        push_job(64'h40, 100, 16'd11, acc);
        collect(1, 40, got);
        n_cmp++; if (got != 1 || req_addr[0] !== 64'h40 || req_len[0] !== 8'd1) begin n_bad++; $display("FAIL small_req: got %0d reqs want (40,1)", got); end
        send_burst(2, 0, id, last, d);
        n_cmp++; if (id !== 16'd11) begin n_bad++; $display("FAIL small_id: got %0d want 11", id); end
        push_job(64'h7F, 64, 16'd12, acc);
        collect(1, 40, got);
        n_cmp++; if (got != 1 || req_addr[0] !== 64'h40 || req_len[0] !== 8'd0) begin n_bad++; $display("FAIL align_req: got %0d reqs want (40,0)", got); end
        send_burst(1, 0, id, last, d);
        push_job(64'h5000, 0, 16'd13, acc);
        n_cmp++; if (acc !== 1'b1) begin n_bad++; $display("FAIL zero_accept: got %b want 1", acc); end
        ok = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (rd_req !== 1'b0 || idle !== 1'b1) ok = 1'b0;
            @(negedge clk);
        end
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL zero_quiet: got rd_req %b idle %b want 0 1", rd_req, idle); end
    endtask

    task automatic test_interleave();
        logic acc, last;
        logic [IW-1:0] id;
        logic [DW-1:0] d;
        int got;
        logic [AW-1:0] exp_a [6] = '{64'h0, 64'h10000, 64'h1000, 64'h11000, 64'h2000, 64'h3000};
        logic [IW-1:0] exp_id [6] = '{16'd5, 16'd9, 16'd5, 16'd9, 16'd5, 16'd5};
        do_reset();
        push_job(64'h0, 16384, 16'd5, acc);
        push_job(64'h10000, 8192, 16'd9, acc);
        collect(6, 100, got);
        n_cmp++; if (got != 6) begin n_bad++; $display("FAIL rr_count: got %0d want 6", got); end
        for (int i = 0; i < got; i++) begin
            n_cmp++; if (req_addr[i] !== exp_a[i] || req_len[i] !== 8'd63) begin n_bad++; $display("FAIL rr_req%0d: got %0h/%0d want %0h/63", i, req_addr[i], req_len[i], exp_a[i]); end
        end
        for (int i = 0; i < 6; i++) begin
            send_burst(64, i * 100, id, last, d);
            n_cmp++; if (id !== exp_id[i] || d !== DW'(i * 100 + 63)) begin n_bad++; $display("FAIL rr_id%0d: got id %0d data %0d want %0d %0d", i, id, d[31:0], exp_id[i], i * 100 + 63); end
        end
        n_cmp++; if (idle !== 1'b1) begin n_bad++; $display("FAIL rr_idle: got %b want 1", idle); end
    endtask

    task automatic test_tag_full();
        logic acc, last, quiet, seen;
        logic [IW-1:0] id;
        logic [DW-1:0] d;
        int got;
        do_reset();
        push_job(64'h0, 81920, 16'd21, acc);
        collect(16, 200, got);
        n_cmp++; if (got != 16) begin n_bad++; $display("FAIL full_count: got %0d want 16", got); end
        quiet = 1'b1;
        rd_req_ack = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (rd_req !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        rd_req_ack = 1'b0;
        n_cmp++; if (quiet !== 1'b1) begin n_bad++; $display("FAIL full_stall: rd_req rose with 16 tags outstanding, want 0"); end
        send_burst(64, 0, id, last, d);
        n_cmp++; if (id !== 16'd21) begin n_bad++; $display("FAIL full_id: got %0d want 21", id); end
        seen = 1'b0;
        for (int c = 0; c < 3 && !seen; c++) begin
            if (rd_req === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        n_cmp++; if (seen !== 1'b1 || rd_addr !== 64'h10000) begin n_bad++; $display("FAIL full_resume: seen %b addr %0h want 1 10000", seen, rd_addr); end
    endtask

    task automatic test_err();
        logic last, ok;
        logic [IW-1:0] id;
        logic [DW-1:0] d;
        do_reset();
        ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (idle !== 1'b1 || rd_req !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL midrst_drop: idle %b rd_req %b want 1 0", idle, rd_req); end
        send_burst(1, 77, id, last, d);
        n_cmp++; if (id !== 16'd0 || d !== DW'(77) || err !== 1'b1) begin n_bad++; $display("FAIL err_beat: id %0d data %0d err %b want 0 77 1", id, d[31:0], err); end
        repeat (5) @(negedge clk);
        n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", err); end
        do_reset();
        n_cmp++; if (err !== 1'b0 || idle !== 1'b1 || rd_req !== 1'b0) begin n_bad++; $display("FAIL err_clear: err %b idle %b rd_req %b want 0 1 0", err, idle, rd_req); end
    endtask

    initial begin
        test_reset();
        test_two_burst();
        test_4k_split();
        test_small_and_zero();
        test_interleave();
        test_tag_full();
        test_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/rd_burst_scheduler.md
Name: rd_burst_scheduler

Overview:
Read-side front end for the decompressor array. It accepts compressed-data jobs and splits each into AXI read bursts, capped by a parametrised maximum and never crossing a 4 KB boundary. It interleaves up to NUM_SLOTS active jobs round-robin and records a job-id tag per issued burst. Returning read beats are delivered downstream with their job id attached, so the data can be steered to the right decompressor.

Parameters:
ADDR_WIDTH, 64, byte address width
DATA_WIDTH, 512, beat width in bits; BEAT_BYTES = DATA_WIDTH/8 (power of two)
LEN_WIDTH, 35, job byte-length width
ID_WIDTH, 16, job id width
MAX_BURST, 64, max beats per burst (1..256)
NUM_SLOTS, 2, concurrently active jobs
TAG_DEPTH, 16, outstanding-burst tag FIFO depth (power of two)

Ports:
clk  in  1  clock
rst_n  in  1  reset
job_valid  in  1  new job offered
job_ready  out  1  a slot is free; job accepted when valid&ready
job_src_addr  in  ADDR_WIDTH  job start byte address
job_length  in  LEN_WIDTH  job length in bytes
job_id  in  ID_WIDTH  job tag
rd_req  out  1  burst request
rd_req_ack  in  1  request accepted
rd_addr  out  ADDR_WIDTH  burst start address
rd_len  out  8  beats-1
data_in  in  DATA_WIDTH  read beat
data_valid_in  in  1  beat valid
data_last_in  in  1  last beat of burst
data_ready_out  out  1  beat accepted when valid&ready
data_out  out  DATA_WIDTH  registered beat
data_id_out  out  ID_WIDTH  job id of data_out
data_last_out  out  1  burst-last of data_out
data_valid_out  out  1  output valid
data_ready_in  in  1  downstream ready
idle  out  1  no slot active, tag FIFO empty, output empty
err  out  1  sticky protocol error

Behaviour:
- Reset rst_n, synchronous, active-low; clock clk.
- Reset values: rd_req=0, rd_addr=0, rd_len=0, data_valid_out=0, data_out/id/last=0, err=0, idle=1, all slots invalid, tag FIFO empty, RR pointer=0, FSM=IDLE.
- Reset mid-operation drops all slots and tags. Late AXI beats after reset are upstream's concern; if they arrive they set err.
- Job accept: beats = ceil(job_length/BEAT_BYTES). Address low log2(BEAT_BYTES) bits are forced to 0.
- job_length=0 is accepted and discarded; no burst and no slot use.
- job_ready is driven from registered slot-valid flags. A slot freed this cycle is usable next cycle. Accepted job fills the lowest free slot.
- FSM IDLE: if any slot is valid and tag count < TAG_DEPTH, go to PICK.
- FSM PICK: select the first valid slot at or after the RR pointer.
  - n = min(remaining, MAX_BURST, (4096 - addr[11:0])/BEAT_BYTES).
  - Register rd_addr=slot addr and rd_len=n-1, assert rd_req, go to REQ.
- FSM REQ: rd_req, rd_addr and rd_len are held stable until rd_req_ack. On ack:
  - rd_req drops.
  - Push the slot's id into the tag FIFO.
  - Slot addr += n*BEAT_BYTES; remaining -= n; slot freed if remaining==0.
  - RR pointer = selected slot+1 (wraps at NUM_SLOTS).
  - Go to IDLE.
- Only one request is outstanding on the request channel. Issue is gated solely by tag FIFO space (STALL is implicit in IDLE).
- Data path uses a one-entry output register. data_ready_out = data_ready_in | ~data_valid_out.
- On a beat accept: data_out/data_last_out capture the input and data_id_out = tag FIFO head. The tag is popped when the accepted beat has data_last_in=1.
- Tag push and pop in the same cycle leave the count unchanged. A pop at full count with a concurrent push is legal.
- Beat accepted while the tag FIFO is empty sets err=1, sticky until reset. The beat is still forwarded with id 0.
- Latency: input beat to data_out is 1 cycle. PICK to rd_req is 1 cycle. Ack to next rd_req is at least 2 cycles.

Test Plan:
- Job (addr 0x1000, len 8192, id 3) -> two requests (0x1000, rd_len 63) then (0x2000, rd_len 63), two tags id 3, slot freed, job_ready=1.
- Job (addr 0x1F80, len 512) -> 4K split: (0x1F80, rd_len 1) then (0x2000, rd_len 5).
- Job len 100 at 0x40 -> single request (0x40, rd_len 1); job len 0 -> accepted, no rd_req, idle stays 1.
- Jobs A (id 5, 0x0, 16384) and B (id 9, 0x10000, 8192) with ack every cycle -> addresses in order 0x0, 0x10000, 0x1000, 0x11000, 0x2000, then A only. Returned bursts carry ids 5, 9, 5, 9, 5 in order.
- Ack all requests but return no data -> after 16 acks rd_req stays 0. Return one 64-beat burst with last -> rd_req reasserts within 3 cycles.
- data_valid_in with empty tag FIFO -> err=1 persists; rst_n=0 one cycle -> err=0, idle=1, rd_req=0.
